// File: rtl/rx_serial_pkg.sv
// Shared definitions for the serial receive path.
//   - Parity-mode constants for the PARITY_MODE parameter.
//   - Receive FSM state type.
//   - clks_per_bit(): integer clocks per line bit.
//   - majority3(): 2-of-3 vote used for mid-bit sampling.
package rx_serial_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                               input int unsigned baud);
    return clock_hz / baud;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO holding received words.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   push, push_data  write request and word; ignored while full unless a pop
//                    happens in the same cycle
//   pop              read request; ignored while empty
//   head             oldest stored word (all zero while empty)
//   empty, full      occupancy flags
//   count            number of stored words, 0..DEPTH
module rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rx_serial_fifo.sv
// Asynchronous UART-style receiver feeding a show-ahead receive FIFO.
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high, clears all state
//   rxd         asynchronous serial input, idle high
//   ready       consumer accepts the head word this cycle
//   valid       FIFO non-empty; head word on data/parity_err/frame_err
//   data        head word data bits
//   parity_err  head word parity mismatch (always 0 without parity)
//   frame_err   head word had a stop bit sampled low
//   overrun     one-cycle pulse: a completed frame was dropped (FIFO full)
//   busy        receiver is inside a frame
//   count       FIFO occupancy
module rx_serial_fifo
  import rx_serial_pkg::*;
#(
  parameter int unsigned CLOCK_HZ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned N_BITS      = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rxd,
  input  logic                        ready,
  output logic                        valid,
  output logic [N_BITS-1:0]           data,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int unsigned CPB    = clks_per_bit(CLOCK_HZ, BAUD_RATE);
  localparam int unsigned MID    = CPB / 2;
  localparam int unsigned TICK_W = $clog2(CPB);
  localparam int unsigned BIT_W  = $clog2(N_BITS);
  localparam int unsigned WIDTH  = N_BITS + 2;

  if (CPB < 8) begin : g_cpb_check
    $error("rx_serial_fifo: CLOCK_HZ/BAUD_RATE must be at least 8");
  end
  if (N_BITS < 5 || N_BITS > 9) begin : g_nbits_check
    $error("rx_serial_fifo: N_BITS must be 5..9");
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_parity_check
    $error("rx_serial_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("rx_serial_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("rx_serial_fifo: DEPTH must be a power of two >= 2");
  end

  // Input synchroniser plus one delay stage for falling-edge detection.
  logic rxd_m, rxd_s, rxd_d;
  logic fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;

  rx_state_t         state, state_nx;
  logic [TICK_W-1:0] tick, tick_nx;
  logic [N_BITS-1:0] shreg, shreg_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic              par_err_q, par_err_nx;
  logic              frm_err_q, frm_err_nx;
  logic              samp_a, samp_b;
  logic              decide;
  logic              bit_val;
  logic              exp_par;
  logic              push;
  logic [WIDTH-1:0]  push_word;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;

  // Tick keeps running modulo CPB across bits, so after the start-bit
  // decision the next decision lands exactly one bit period later.
  assign decide  = (state != ST_IDLE) && (tick == TICK_W'(MID + 1));
  assign bit_val = majority3(samp_a, samp_b, rxd_s);
  assign exp_par = (PARITY_MODE == PARITY_ODD) ? ~(^shreg) : (^shreg);

  always_ff @(posedge clock) begin
    if (reset) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (tick == TICK_W'(MID - 1)) samp_a <= rxd_s;
      if (tick == TICK_W'(MID))     samp_b <= rxd_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick      <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      tick      <= tick_nx;
      shreg     <= shreg_nx;
      bit_cnt   <= bit_cnt_nx;
      par_err_q <= par_err_nx;
      frm_err_q <= frm_err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    par_err_nx = par_err_q;
    frm_err_nx = frm_err_q;
    push       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_nx   = ST_START;
          bit_cnt_nx = '0;
          par_err_nx = 1'b0;
          frm_err_nx = 1'b0;
        end
      end
      ST_START: begin
        if (decide) state_nx = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide) begin
          shreg_nx = {bit_val, shreg[N_BITS-1:1]};
          if (bit_cnt == BIT_W'(N_BITS - 1)) begin
            bit_cnt_nx = '0;
            state_nx   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          par_err_nx = (bit_val != exp_par);
          state_nx   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          frm_err_nx = frm_err_q | ~bit_val;
          // The word is pushed at the last stop decision; the rest of the
          // stop bit is spent in IDLE so an early start edge is not missed.
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            push     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_nx = '0;
    if (state != ST_IDLE && state_nx != ST_IDLE) begin
      tick_nx = (tick == TICK_W'(CPB - 1)) ? '0 : tick + 1'b1;
    end
  end

  assign push_word = {frm_err_nx, par_err_q, shreg};
  assign pop       = valid & ready;

  rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      ({frame_err, parity_err, data}),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= push & fifo_full & ~pop;
  end

  assign valid = ~fifo_empty;
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_rx_serial_fifo.sv
module tb_rx_serial_fifo;

  localparam int unsigned TB_CLK_HZ = 1_600_000;
  localparam int unsigned TB_BAUD   = 100_000;
  localparam int unsigned CPB       = TB_CLK_HZ / TB_BAUD;  // 16

  logic       clock = 1'b0;
  logic       reset, rxd, ready;
  logic       e_valid, e_perr, e_ferr, e_ovr, e_busy;
  logic [7:0] e_data;
  logic [2:0] e_count;
  logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;
  logic [7:0] o_data;
  logic [2:0] o_count;

  int checks = 0;
  int errors = 0;
  int ovr_e  = 0;
  int ovr_o  = 0;

  logic [9:0]  cap_e, cap_o;
  logic        cap_ov, after_valid;
  logic [2:0]  cap_cnt;
  int          lat;
  logic [19:0] q[$];
  bit          done;

  always #5 clock = ~clock;

  rx_serial_fifo #(
    .CLOCK_HZ(TB_CLK_HZ), .BAUD_RATE(TB_BAUD), .N_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1), .DEPTH(4)
  ) dut_even (
    .clock(clock), .reset(reset), .rxd(rxd), .ready(ready),
    .valid(e_valid), .data(e_data), .parity_err(e_perr), .frame_err(e_ferr),
    .overrun(e_ovr), .busy(e_busy), .count(e_count)
  );

  rx_serial_fifo #(
    .CLOCK_HZ(TB_CLK_HZ), .BAUD_RATE(TB_BAUD), .N_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(1), .DEPTH(4)
  ) dut_odd (
    .clock(clock), .reset(reset), .rxd(rxd), .ready(ready),
    .valid(o_valid), .data(o_data), .parity_err(o_perr), .frame_err(o_ferr),
    .overrun(o_ovr), .busy(o_busy), .count(o_count)
  );

  always @(negedge clock) begin
    if (e_ovr) ovr_e++;
    if (o_ovr) ovr_o++;
  end

  // Expected {frame_err, parity_err, data} from the frame as sent on the line.
  function automatic logic [9:0] model_word(input logic [7:0] d, input logic pbit,
                                            input logic sbit, input bit odd);
    int   ones;
    logic perr;
    ones = $countones(d) + int'(pbit);
    perr = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return {~sbit, perr, d};
  endfunction

  function automatic logic even_bit(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input int glitch_bit);
    logic [10:0] bits;
    bits = {sbit, pbit, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      for (int unsigned c = 0; c < CPB; c++) begin
        @(negedge clock);
        rxd = (b == glitch_bit && c == CPB / 2 + 1) ? ~bits[b] : bits[b];
      end
    end
    @(negedge clock);
    rxd = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (e_valid) begin
        seen    = 1'b1;
        lat     = i;
        cap_e   = {e_ferr, e_perr, e_data};
        cap_o   = {o_ferr, o_perr, o_data};
        cap_ov  = o_valid;
        cap_cnt = e_count;
      end
    end
    @(negedge clock);
    after_valid = e_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1; rxd = 1'b1; ready = 1'b0;
    idle(3);
    checks++;
    if ({e_valid, e_data, e_perr, e_ferr, e_ovr, e_busy, e_count,
         o_valid, o_data, o_perr, o_ferr, o_ovr, o_busy, o_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got e=%b_%h_%b%b%b%b_%0d o=%b_%h_%b%b%b%b_%0d want all 0",
               e_valid, e_data, e_perr, e_ferr, e_ovr, e_busy, e_count,
               o_valid, o_data, o_perr, o_ferr, o_ovr, o_busy, o_count);
    end
    reset = 1'b0;
    idle(4);
    checks++;
    if ({e_valid, e_busy, o_valid, o_busy} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid/busy %b%b want 00", e_valid, e_busy);
    end
  endtask

  task automatic test_single_word;
    bit seen;
    ready = 1'b1;
    fork
      send_frame(8'h56, 1'b0, 1'b1, -1);
      wait_valid(14 * CPB, seen);
    join
    checks++;
    if (!seen) begin errors++; $display("FAIL v_timeout: got no valid want valid"); end
    checks++;
    if (cap_e !== model_word(8'h56, 1'b0, 1'b1, 0)) begin
      errors++; $display("FAIL v_even_word: got %h want %h", cap_e, model_word(8'h56, 1'b0, 1'b1, 0));
    end
    checks++;
    if ({cap_ov, cap_o} !== {1'b1, model_word(8'h56, 1'b0, 1'b1, 1)}) begin
      errors++; $display("FAIL v_odd_word: got %b_%h want 1_%h", cap_ov, cap_o, model_word(8'h56, 1'b0, 1'b1, 1));
    end
    checks++;
    if (cap_cnt !== 3'd1) begin errors++; $display("FAIL v_count: got %0d want 1", cap_cnt); end
    checks++;
    if (after_valid !== 1'b0) begin errors++; $display("FAIL v_pulse: got valid %b after pop want 0", after_valid); end
    checks++;
    if (lat < int'(CPB * 21 / 2) || lat > int'(CPB * 21 / 2 + 8)) begin
      errors++; $display("FAIL v_latency: got %0d cycles want %0d..%0d", lat, CPB * 21 / 2, CPB * 21 / 2 + 8);
    end
  endtask

  task automatic test_parity;
    bit seen;
    ready = 1'b1;
    idle(3);
    fork
      send_frame(8'h7B, 1'b1, 1'b1, -1);
      wait_valid(14 * CPB, seen);
    join
    checks++;
    if (!seen || cap_e !== model_word(8'h7B, 1'b1, 1'b1, 0)) begin
      errors++; $display("FAIL par_even: got seen=%b %h want %h", seen, cap_e, model_word(8'h7B, 1'b1, 1'b1, 0));
    end
    checks++;
    if (cap_o !== model_word(8'h7B, 1'b1, 1'b1, 1)) begin
      errors++; $display("FAIL par_odd: got %h want %h", cap_o, model_word(8'h7B, 1'b1, 1'b1, 1));
    end
  endtask

  task automatic test_framing;
    bit seen;
    ready = 1'b1;
    idle(3);
    fork
      send_frame(8'h56, 1'b0, 1'b0, -1);
      wait_valid(14 * CPB, seen);
    join
    checks++;
    if (!seen || cap_e !== model_word(8'h56, 1'b0, 1'b0, 0)) begin
      errors++; $display("FAIL frame_err_word: got seen=%b %h want %h", seen, cap_e, model_word(8'h56, 1'b0, 1'b0, 0));
    end
    idle(4);
    fork
      send_frame(8'h7B, 1'b0, 1'b1, -1);
      wait_valid(14 * CPB, seen);
    join
    checks++;
    if (!seen || cap_e !== model_word(8'h7B, 1'b0, 1'b1, 0) || cap_o !== model_word(8'h7B, 1'b0, 1'b1, 1)) begin
      errors++; $display("FAIL frame_recover: got seen=%b e=%h o=%h want e=%h o=%h", seen, cap_e, cap_o,
                         model_word(8'h7B, 1'b0, 1'b1, 0), model_word(8'h7B, 1'b0, 1'b1, 1));
    end
  endtask

  task automatic test_false_start;
    int vseen;
    ready = 1'b1;
    idle(3);
    @(negedge clock) rxd = 1'b0;
    idle(3);
    @(negedge clock) rxd = 1'b1;
    idle(2);
    checks++;
    if (e_busy !== 1'b1) begin errors++; $display("FAIL fs_busy_high: got %b want 1", e_busy); end
    vseen = 0;
    for (int unsigned i = 0; i < 3 * CPB; i++) begin
      @(negedge clock);
      if (e_valid || o_valid) vseen++;
    end
    checks++;
    if (vseen != 0) begin errors++; $display("FAIL fs_no_word: got %0d valid cycles want 0", vseen); end
    checks++;
    if ({e_busy, o_busy, e_count} !== 5'b0) begin
      errors++; $display("FAIL fs_idle: got busy=%b%b count=%0d want 00 0", e_busy, o_busy, e_count);
    end
  endtask

  task automatic test_glitch;
    bit seen;
    ready = 1'b1;
    idle(3);
    fork
      send_frame(8'h56, 1'b0, 1'b1, 1);
      wait_valid(14 * CPB, seen);
    join
    checks++;
    if (!seen || cap_e !== model_word(8'h56, 1'b0, 1'b1, 0)) begin
      errors++; $display("FAIL glitch_word: got seen=%b %h want %h", seen, cap_e, model_word(8'h56, 1'b0, 1'b1, 0));
    end
  endtask

  task automatic test_overrun;
    int         base_e, base_o;
    logic [7:0] w;
    ready = 1'b0;
    idle(3);
    base_e = ovr_e; base_o = ovr_o;
    for (int k = 1; k <= 4; k++) begin
      w = 8'(k);
      send_frame(w, even_bit(w), 1'b1, -1);
      idle(3);
    end
    checks++;
    if (e_count !== 3'd4 || o_count !== 3'd4 || ovr_e != base_e) begin
      errors++; $display("FAIL ovr_fill: got count=%0d/%0d overruns=%0d want 4/4 0", e_count, o_count, ovr_e - base_e);
    end
    send_frame(8'h05, even_bit(8'h05), 1'b1, -1);
    idle(CPB);
    checks++;
    if (ovr_e - base_e != 1 || ovr_o - base_o != 1) begin
      errors++; $display("FAIL ovr_pulse: got %0d/%0d cycles want 1/1", ovr_e - base_e, ovr_o - base_o);
    end
    checks++;
    if (e_count !== 3'd4 || e_valid !== 1'b1 || e_data !== 8'h01) begin
      errors++; $display("FAIL ovr_kept: got count=%0d valid=%b head=%h want 4 1 01", e_count, e_valid, e_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (e_valid !== 1'b1 || e_data !== 8'(i + 1) || e_count !== 3'(4 - i) || o_data !== 8'(i + 1)) begin
        errors++; $display("FAIL ovr_drain%0d: got valid=%b data=%h count=%0d want 1 %h %0d",
                           i, e_valid, e_data, e_count, 8'(i + 1), 4 - i);
      end
      ready = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (e_valid !== 1'b0 || e_count !== 3'd0 || o_count !== 3'd0) begin
      errors++; $display("FAIL ovr_empty: got valid=%b count=%0d want 0 0", e_valid, e_count);
    end
    idle(3);
    checks++;
    if (e_count !== 3'd0 || e_valid !== 1'b0) begin
      errors++; $display("FAIL ready_when_empty: got count=%0d valid=%b want 0 0", e_count, e_valid);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit seen;
    ready = 1'b0;
    idle(3);
    send_frame(8'h11, even_bit(8'h11), 1'b1, -1);
    idle(3);
    send_frame(8'h22, even_bit(8'h22), 1'b1, -1);
    idle(3);
    checks++;
    if (e_count !== 3'd2) begin errors++; $display("FAIL rst_queued: got %0d want 2", e_count); end
    @(negedge clock) rxd = 1'b0;
    idle(int'(CPB) - 1);
    @(negedge clock) rxd = 1'b1;
    idle(int'(CPB / 2));
    checks++;
    if (e_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_mid: got %b want 1", e_busy); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({e_valid, e_count, e_busy, e_data, o_valid, o_count, o_busy} !== '0) begin
      errors++; $display("FAIL rst_mid_clear: got valid=%b count=%0d busy=%b data=%h want 0 0 0 00",
                         e_valid, e_count, e_busy, e_data);
    end
    reset = 1'b0;
    ready = 1'b1;
    idle(4);
    fork
      send_frame(8'h56, 1'b0, 1'b1, -1);
      wait_valid(14 * CPB, seen);
    join
    checks++;
    if (!seen || cap_e !== model_word(8'h56, 1'b0, 1'b1, 0) || cap_cnt !== 3'd1) begin
      errors++; $display("FAIL rst_next_frame: got seen=%b %h count=%0d want %h 1",
                         seen, cap_e, cap_cnt, model_word(8'h56, 1'b0, 1'b1, 0));
    end
  endtask

  task automatic test_random;
    int base_e;
    base_e = ovr_e;
    done = 1'b0;
    q.delete();
    idle(3);
    fork
      begin : sender
        logic [7:0] d;
        logic       p, s;
        for (int f = 0; f < 20; f++) begin
          d = 8'($urandom);
          p = 1'($urandom);
          s = ($urandom_range(0, 3) != 0);
          q.push_back({model_word(d, p, s, 1), model_word(d, p, s, 0)});
          send_frame(d, p, s, -1);
          idle($urandom_range(2, 20));
        end
        done = 1'b1;
      end
      begin : monitor
        int cyc;
        cyc = 0;
        while (!(done && q.size() == 0) && cyc < 20000) begin
          @(negedge clock);
          cyc++;
          if (e_valid) begin
            checks++;
            if (q.size() == 0) begin
              errors++; $display("FAIL rand_extra: got word %h want none", {e_ferr, e_perr, e_data});
            end else if ({e_ferr, e_perr, e_data} !== q[0][9:0] ||
                         {o_valid, o_ferr, o_perr, o_data} !== {1'b1, q[0][19:10]}) begin
              errors++; $display("FAIL rand_word: got e=%h o=%b_%h want e=%h o=1_%h",
                                 {e_ferr, e_perr, e_data}, o_valid, {o_ferr, o_perr, o_data},
                                 q[0][9:0], q[0][19:10]);
            end
          end
          ready = 1'($urandom);
          if (e_valid && ready && q.size() != 0) void'(q.pop_front());
        end
      end
    join
    idle(2);
    checks++;
    if (q.size() != 0 || e_valid !== 1'b0 || e_count !== 3'd0 || ovr_e != base_e) begin
      errors++; $display("FAIL rand_end: got pending=%0d valid=%b count=%0d overruns=%0d want 0 0 0 0",
                         q.size(), e_valid, e_count, ovr_e - base_e);
    end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_parity;
    test_framing;
    test_false_start;
    test_glitch;
    test_overrun;
    test_reset_mid_frame;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_serial_fifo.md
Name: rx_serial_fifo

Overview:
Parametrised successor to the single-word serial receiver: asynchronous UART-style receiver with configurable word width, parity mode and stop-bit count.
- Majority-vote mid-bit sampling and false-start rejection.
- Separate parity, framing and overrun error reporting.
- Show-ahead receive FIFO drained by a valid/ready handshake.
- Sits between the board RX pin and the command-decoding logic; replaces the single-shot fim/data interface.

Parameters:
CLOCK_HZ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate; CLKS_PER_BIT = CLOCK_HZ/BAUD_RATE (5208 at defaults), integer-truncated; elaboration error if < 8
N_BITS, 8, data bits per frame, 5..9, LSB first
PARITY_MODE, 1, 0 = none, 1 = even (parity bit = ^data), 2 = odd (parity bit = ~^data)
STOP_BITS, 1, 1 or 2
DEPTH, 4, FIFO entries, power of two >= 2

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
rxd  in  1  asynchronous serial input, idle high
ready  in  1  consumer accepts head word this cycle
valid  out  1  FIFO non-empty; head word on data/parity_err/frame_err
data  out  N_BITS  head word data
parity_err  out  1  head word parity mismatch (0 when PARITY_MODE = 0)
frame_err  out  1  head word had a stop bit sampled 0
overrun  out  1  one-cycle pulse: completed frame dropped because FIFO full
busy  out  1  FSM not IDLE
count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
Reset values:
- valid/data/parity_err/frame_err/overrun/busy/count = 0.
- Synchroniser flops = 1.
- FSM = IDLE.
- Reset mid-frame aborts the frame, discards the partial word and empties the FIFO.

Input path:
- rxd passes through 2-flop synchroniser (rxd_s); 2-cycle input latency.
- Falling edge detected on rxd_s (prev 1, now 0).

Sampling:
- Bit counter tick counts 0..CLKS_PER_BIT-1; mid = CLKS_PER_BIT/2.
- Samples taken at tick mid-1, mid, mid+1.
- Bit value = majority of the 3 samples; value is decided at tick mid+1.

FSM states and transitions:
- IDLE: on falling edge -> START, tick = 0.
- START: at mid+1, majority 1 -> IDLE (false start, no word, no error); majority 0 -> DATA, tick realigned so the next decision is exactly CLKS_PER_BIT later.
- DATA: N_BITS decisions, shifted in LSB first -> PARITY if PARITY_MODE != 0, else -> STOP.
- PARITY: one decision; parity_err_int = (bit != expected).
- STOP: STOP_BITS decisions; frame_err_int = 1 if any is 0.
  - After the last stop decision: push {frame_err_int, parity_err_int, data}, then -> IDLE the same cycle.
  - No wait for the end of the stop bit; a new start edge is accepted immediately.
  - Frame with frame_err is still pushed.

Latency: valid rises one clock after the push cycle when the FIFO was empty.

FIFO:
- Show-ahead; head registered outputs.
- Pop when valid && ready.
- Push when full && no pop: word dropped, overrun = 1 for exactly one cycle, contents unchanged.
- Push and pop same cycle when full: both happen, no overrun, count unchanged.
- Push while empty: no same-cycle bypass; valid next cycle.
- Pointers wrap modulo DEPTH.
- count = writes - reads, never exceeds DEPTH.
- ready while !valid is ignored.

Errors: error flags belong to the word and travel with it; no sticky status.

Decomposition:
Package rx_serial_pkg:
- PARITY_NONE/EVEN/ODD constants.
- FSM state encoding (IDLE, START, DATA, PARITY, STOP).
- Function clks_per_bit(clock_hz, baud).
- Function majority3.
Sub-module rx_fifo (DEPTH, WIDTH = N_BITS+2), synchronous show-ahead FIFO with push/pop/full/empty/count. Synchroniser, baud tick counter and FSM stay in rx_serial_fifo.

Test Plan:
1. Defaults, even parity, ready = 1: send 0x56 ('V') with parity 0, stop 1 -> valid pulses 1 cycle, data = 0x56, parity_err = 0, frame_err = 0; data ready ~10.5 bit times after start edge + 2 sync cycles.
2. Send 0x7B ('{') with parity 1 -> data = 0x7B, parity_err = 1. Repeat with PARITY_MODE = 2 and parity 1 -> parity_err = 0.
3. Stop bit driven 0 -> word 0x56 delivered with frame_err = 1. Line returned high, next frame 0x7B (parity 0) -> clean.
4. rxd low for 100 cycles (< 2604), then high -> busy returns 0, no valid, no errors. Also: single-cycle 1-glitch at tick mid within a data bit -> majority keeps correct data.
5. DEPTH = 4, ready = 0: send 0x01..0x05 -> count = 4, overrun pulses once after frame 5. Then ready = 1 -> pops 0x01, 0x02, 0x03, 0x04 in order, count -> 0, valid = 0.
6. Reset asserted mid-DATA of frame, with 2 words queued -> next cycle valid = 0, count = 0, busy = 0. Following frame 0x56 is received correctly.
